// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider and its optional gate generator.
package clk_div_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int MIN_HALF  = 1;

    typedef enum logic [1:0] {
        GATE_IDLE,
        GATE_ARMED,
        GATE_OPEN
    } gate_state_t;

endpackage

// File: rtl/clk_div_gate.sv
// One-period measurement window generator, opened and closed on consecutive rising-edge ticks.
module clk_div_gate
    import clk_div_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_tick,
    input  logic i_start,
    output logic o_gate,
    output logic o_gate_done
);

    gate_state_t r_state;
    logic        r_gate;
    logic        r_gate_done;

    // i_tick is the next-cycle tick strobe, so gate registers alongside the divider's tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= GATE_IDLE;
            r_gate      <= 1'b0;
            r_gate_done <= 1'b0;
        end else begin
            r_gate_done <= 1'b0;
            if (i_en) begin
                case (r_state)
                    GATE_IDLE: begin
                        if (i_start) begin
                            r_state <= GATE_ARMED;
                        end
                    end
                    GATE_ARMED: begin
                        if (i_tick) begin
                            r_state <= GATE_OPEN;
                            r_gate  <= 1'b1;
                        end
                    end
                    GATE_OPEN: begin
                        if (i_tick) begin
                            r_state     <= GATE_IDLE;
                            r_gate      <= 1'b0;
                            r_gate_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= GATE_IDLE;
                        r_gate  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_gate      = r_gate;
    assign o_gate_done = r_gate_done;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty clock divider with tick/edge strobes and boundary-aligned updates.
// Optional measurement gate generator enabled by defining CLK_DIV_GATE_EN.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] half_in,
    input  logic             half_wr,
`ifdef CLK_DIV_GATE_EN
    input  logic             gate_start,
    output logic             gate,
    output logic             gate_done,
`endif
    output logic             div_out,
    output logic             tick,
    output logic             edge_p,
    output logic [CNT_W-1:0] half_cur,
    output logic             upd_pend
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] f_clamp_half(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : v;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half_cur;
    logic [CNT_W-1:0] r_pending;
    logic             r_upd_pend;
    logic             r_div_out;
    logic             r_tick;
    logic             r_edge_p;

    logic [CNT_W-1:0] w_h;
    logic             w_wrap;
    logic             w_tick_nxt;

    assign w_h        = f_clamp_half(r_half_cur);
    assign w_wrap     = (r_cnt == (w_h - ONE));
    assign w_tick_nxt = en & w_wrap & ~r_div_out;

    // A boundary write is handled after the apply step so it lands in pending for the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_half_cur <= RST_HALF;
            r_pending  <= '0;
            r_upd_pend <= 1'b0;
            r_div_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_edge_p   <= 1'b0;
        end else begin
            r_tick   <= 1'b0;
            r_edge_p <= 1'b0;
            if (!en) begin
                if (half_wr) begin
                    r_half_cur <= f_clamp_half(half_in);
                    r_cnt      <= '0;
                    r_upd_pend <= 1'b0;
                end
            end else begin
                if (w_wrap) begin
                    r_cnt     <= '0;
                    r_div_out <= ~r_div_out;
                    r_edge_p  <= 1'b1;
                    r_tick    <= ~r_div_out;
                    if (r_upd_pend) begin
                        r_half_cur <= r_pending;
                    end
                    r_upd_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
                if (half_wr) begin
                    r_pending  <= f_clamp_half(half_in);
                    r_upd_pend <= 1'b1;
                end
            end
        end
    end

    assign div_out  = r_div_out;
    assign tick     = r_tick;
    assign edge_p   = r_edge_p;
    assign half_cur = r_half_cur;
    assign upd_pend = r_upd_pend;

`ifdef CLK_DIV_GATE_EN
    clk_div_gate u_gate (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_tick      (w_tick_nxt),
        .i_start     (gate_start),
        .o_gate      (gate),
        .o_gate_done (gate_done)
    );
`else
    logic w_unused_tick_nxt;
    assign w_unused_tick_nxt = w_tick_nxt;
`endif

endmodule
